// File: rtl/ppa_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder and its reference model.
package ppa_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SEG   = 16;

  // Number of carry-select segments (and pipeline stages); clamped to 1 on a bad
  // configuration so arrays stay legal while the elaboration check reports it.
  function automatic int calc_nseg(input int width, input int seg);
    if (seg <= 0 || seg > width) begin
      return 1;
    end
    return width / seg;
  endfunction

  // Layout of one in-flight operation at the default width.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] sum;
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] b;
    logic                     carry;
    logic                     sub;
  } stage_rec_t;

endpackage

// File: rtl/cselect_segment.sv
// Combinational SEG-bit carry-select slice: both carry-in candidates are summed
// up front so the incoming carry only has to steer a final mux.
module cselect_segment
  import ppa_adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] sum_c0;
  logic [SEG:0] sum_c1;

  // Precompute carry-0 and carry-1 results, select on cin, recover the carry into the MSB
  always_comb begin
    sum_c0      = {1'b0, a} + {1'b0, b};
    sum_c1      = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
    {cout, sum} = cin ? sum_c1 : sum_c0;
    cmsb        = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];
  end

endmodule

// File: rtl/pipelined_cselect_adder.sv
// Pipelined carry-select adder/subtractor: one segment resolved per stage, segment
// carry registered between stages, single global stall from the output side.
module pipelined_cselect_adder
  import ppa_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = calc_nseg(WIDTH, SEG);

  if ((SEG <= 0) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
    $error("pipelined_cselect_adder: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic             adv;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             src_c;

  logic [WIDTH-1:0] a_d   [NSEG];
  logic [WIDTH-1:0] b_d   [NSEG];
  logic [WIDTH-1:0] sum_d [NSEG];
  logic [NSEG-1:0]  valid_d;
  logic [NSEG-1:0]  carry_d;
  logic [NSEG-1:0]  ovf_d;

  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] sum_q [NSEG];
  logic [NSEG-1:0]  valid_q;
  logic [NSEG-1:0]  carry_q;
  logic [NSEG-1:0]  ovf_q;

  logic [SEG-1:0]   seg_sum  [NSEG];
  logic [NSEG-1:0]  seg_cout;
  logic [NSEG-1:0]  seg_cmsb;

  logic             unused_bits;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[NSEG-1];
  assign s         = sum_q[NSEG-1];
  assign cout      = carry_q[NSEG-1];
  assign ovf       = ovf_q[NSEG-1];

  // Operands of the last stage and the overflow of earlier stages are never consumed
  assign unused_bits = ^{a_q[NSEG-1], b_q[NSEG-1], ovf_q};

  // Fold subtract into the operand and carry-in; a bubble enters as all-zero data
  always_comb begin
    src_a = '0;
    src_b = '0;
    src_c = 1'b0;
    if (in_valid) begin
      src_a = x1;
      src_b = sub ? ~x2 : x2;
      src_c = sub | cin;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG-1:0] seg_a;
    logic [SEG-1:0] seg_b;
    logic           seg_cin;

    if (k == 0) begin : g_src
      assign seg_a   = src_a[0 +: SEG];
      assign seg_b   = src_b[0 +: SEG];
      assign seg_cin = src_c;
    end else begin : g_pipe
      assign seg_a   = a_q[k-1][k*SEG +: SEG];
      assign seg_b   = b_q[k-1][k*SEG +: SEG];
      assign seg_cin = carry_q[k-1];
    end

    cselect_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (seg_cin),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k]),
      .cmsb (seg_cmsb[k])
    );
  end

  // Each stage takes the previous stage's record and inserts its own segment result
  always_comb begin
    a_d[0]     = src_a;
    b_d[0]     = src_b;
    sum_d[0]   = '0;
    valid_d[0] = in_valid;
    for (int k = 1; k < NSEG; k++) begin
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
      sum_d[k]   = sum_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      sum_d[k][k*SEG +: SEG] = seg_sum[k];
      carry_d[k]             = seg_cout[k];
      ovf_d[k]               = seg_cmsb[k] ^ seg_cout[k];
    end
  end

  // Pipeline registers advance together on adv and are cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
    end else if (adv) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_cselect_adder.sv
// Directed bench for the pipelined carry-select adder: default 32/16 instance plus a 64/8 instance.
module tb_pipelined_cselect_adder;
  import ppa_adder_pkg::*;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        cout;
  logic        ovf;

  logic        in_valid_w;
  logic        in_ready_w;
  logic [63:0] x1_w;
  logic [63:0] x2_w;
  logic        cin_w;
  logic        sub_w;
  logic        out_valid_w;
  logic        out_ready_w;
  logic [63:0] s_w;
  logic        cout_w;
  logic        ovf_w;

  int checks = 0;
  int errors = 0;

  pipelined_cselect_adder #(.WIDTH(32), .SEG(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  pipelined_cselect_adder #(.WIDTH(64), .SEG(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .x1(x1_w), .x2(x2_w), .cin(cin_w), .sub(sub_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .s(s_w), .cout(cout_w), .ovf(ovf_w)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent arithmetic reference: widen, add, derive overflow from operand/result signs
  function automatic exp_t refModel(input stage_rec_t op);
    logic [31:0] beff;
    logic        c0;
    logic [32:0] full;
    exp_t        r;
    beff = op.sub ? ~op.b : op.b;
    c0   = op.sub ? 1'b1 : op.carry;
    full = {1'b0, op.a} + {1'b0, beff} + {32'd0, c0};
    r.s  = full[31:0];
    r.c  = full[32];
    r.o  = (op.a[31] == beff[31]) && (full[31] != op.a[31]);
    return r;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] es, input logic ec, input logic eo);
    checkValue({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkValue({tag, "_s"}, {32'd0, s}, {32'd0, es});
    checkValue({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    checkValue({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sb);
    x1       = a;
    x2       = b;
    cin      = c;
    sub      = sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic sb, input logic [31:0] es, input logic ec, input logic eo);
    applyStimulus(a, b, c, sb);
    checkValue({tag, "_latency"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput(tag, es, ec, eo);
    @(posedge clk);
    #1;
    checkValue({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic runWide(input string tag, input logic [63:0] a, input logic [63:0] b, input logic c,
                         input logic [63:0] es, input logic ec);
    x1_w       = a;
    x2_w       = b;
    cin_w      = c;
    sub_w      = 1'b0;
    in_valid_w = 1'b1;
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkValue({tag, "_latency"}, {63'd0, out_valid_w}, 64'd0);
    @(posedge clk);
    #1;
    checkValue({tag, "_valid"}, {63'd0, out_valid_w}, 64'd1);
    checkValue({tag, "_s"}, s_w, es);
    checkValue({tag, "_cout"}, {63'd0, cout_w}, {63'd0, ec});
    @(posedge clk);
    #1;
    checkValue({tag, "_drain"}, {63'd0, out_valid_w}, 64'd0);
  endtask

  initial begin
    exp_t        expq[$];
    exp_t        e;
    stage_rec_t  op;
    int          sent;
    int          rcvd;
    int          cyc;
    logic        hold_flag;
    logic [31:0] held_s;
    logic        held_c;
    logic        held_o;

    rst         = 1'b1;
    in_valid    = 1'b0;
    x1          = '0;
    x2          = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    out_ready   = 1'b1;
    in_valid_w  = 1'b0;
    x1_w        = '0;
    x2_w        = '0;
    cin_w       = 1'b0;
    sub_w       = 1'b0;
    out_ready_w = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkValue("reset_s", {32'd0, s}, 64'd0);
    checkValue("reset_cout", {63'd0, cout}, 64'd0);
    checkValue("reset_ovf", {63'd0, ovf}, 64'd0);
    checkValue("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkValue("reset_wide_s", s_w, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed arithmetic vectors");
    runOp("add_neg", 32'd10000, 32'hFFFFFF9C, 1'b1, 1'b0, 32'd9901, 1'b1, 1'b0);
    runOp("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    runOp("sub_cin_ignored", 32'd9, 32'd3, 1'b0, 1'b1, 32'd6, 1'b1, 1'b0);
    runOp("pos_ovf", 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1);
    runOp("neg_ovf", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    runOp("sub_ovf", 32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    runOp("full_wrap", 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    runOp("seg_carry", 32'h0000FFFF, 32'd1, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);

    $display("[TB] 64-bit, 8-bit segment instance");
    runWide("wide_seg_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
    runWide("wide_full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1);

    $display("[TB] streaming with random back-pressure");
    sent      = 0;
    rcvd      = 0;
    cyc       = 0;
    hold_flag = 1'b0;
    held_s    = '0;
    held_c    = 1'b0;
    held_o    = 1'b0;
    while (rcvd < 100 && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 100) begin
        in_valid = 1'b1;
        x1       = $urandom;
        x2       = $urandom;
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold_flag) begin
        checkValue("stall_hold_valid", {63'd0, out_valid}, 64'd1);
        checkValue("stall_hold_s", {32'd0, s}, {32'd0, held_s});
        checkValue("stall_hold_cout", {63'd0, cout}, {63'd0, held_c});
        checkValue("stall_hold_ovf", {63'd0, ovf}, {63'd0, held_o});
      end
      if (out_valid && out_ready) begin
        checkValue("stream_in_ready", {63'd0, in_ready}, 64'd1);
        checkValue("stream_not_spurious", {63'd0, expq.size() > 0}, 64'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          checkValue("stream_s", {32'd0, s}, {32'd0, e.s});
          checkValue("stream_cout", {63'd0, cout}, {63'd0, e.c});
          checkValue("stream_ovf", {63'd0, ovf}, {63'd0, e.o});
        end
        rcvd++;
        hold_flag = 1'b0;
      end else if (out_valid) begin
        checkValue("stall_in_ready", {63'd0, in_ready}, 64'd0);
        hold_flag = 1'b1;
        held_s    = s;
        held_c    = cout;
        held_o    = ovf;
      end else begin
        hold_flag = 1'b0;
      end
      if (in_valid && in_ready) begin
        op.valid = 1'b1;
        op.sum   = '0;
        op.a     = x1;
        op.b     = x2;
        op.carry = cin;
        op.sub   = sub;
        expq.push_back(refModel(op));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checkValue("stream_count", 64'(rcvd), 64'd100);
    checkValue("stream_leftover", 64'(expq.size()), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset with operations in flight");
    x1       = 32'd111;
    x2       = 32'd222;
    cin      = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    x1 = 32'd333;
    x2 = 32'd444;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkValue("inflight_valid", {63'd0, out_valid}, 64'd1);
    checkValue("inflight_s", {32'd0, s}, 64'd333);
    rst = 1'b1;
    #1;
    checkValue("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkValue("midrst_s", {32'd0, s}, 64'd0);
    checkValue("midrst_cout", {63'd0, cout}, 64'd0);
    checkValue("midrst_ovf", {63'd0, ovf}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkValue("postrst_discard", {63'd0, out_valid}, 64'd0);
    runOp("postrst_op", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
